// File: rtl/param_memory_module.sv
// Parametrised register file: one write port, two registered read ports,
// write-first bypass and a hardware clear sweep after reset or on request.
module param_memory_module #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  clearReq,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  readEnable1,
  input  logic [ADDR_WIDTH-1:0] readAddress1,
  input  logic                  readEnable2,
  input  logic [ADDR_WIDTH-1:0] readAddress2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic                  readValid1,
  output logic                  readValid2,
  output logic                  busy,
  output logic                  writeDropped
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clearAddr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    ready;
  logic                    hit1;
  logic                    hit2;

  assign ready = (state == READY);
  assign hit1  = writeEnable && (writeAddress == readAddress1);
  assign hit2  = writeEnable && (writeAddress == readAddress2);

  // Sweep sequencing, busy flag and dropped-write pulse
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state        <= CLEAR;
      clearAddr    <= '0;
      busy         <= 1'b1;
      writeDropped <= 1'b0;
    end else begin
      writeDropped <= !ready && writeEnable;
      if (!ready) begin
        if (clearAddr == LAST) begin
          state     <= READY;
          busy      <= 1'b0;
          clearAddr <= '0;
        end else begin
          clearAddr <= clearAddr + 1'b1;
        end
      end else if (clearReq) begin
        state     <= CLEAR;
        busy      <= 1'b1;
        clearAddr <= '0;
      end
    end
  end

  // Storage: the sweep owns the write port while clearing
  always_ff @(posedge clk) begin
    if (resetN) begin
      if (!ready) begin
        mem[clearAddr] <= CLEAR_VALUE;
      end else if (writeEnable) begin
        mem[writeAddress] <= writeData;
      end
    end
  end

  // Read port 1 with write-first bypass
  always_ff @(posedge clk) begin
    if (!resetN) begin
      readData1  <= '0;
      readValid1 <= 1'b0;
    end else if (ready && readEnable1) begin
      readData1  <= hit1 ? writeData : mem[readAddress1];
      readValid1 <= 1'b1;
    end else begin
      readValid1 <= 1'b0;
    end
  end

  // Read port 2 with write-first bypass
  always_ff @(posedge clk) begin
    if (!resetN) begin
      readData2  <= '0;
      readValid2 <= 1'b0;
    end else if (ready && readEnable2) begin
      readData2  <= hit2 ? writeData : mem[readAddress2];
      readValid2 <= 1'b1;
    end else begin
      readValid2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_memory_module.sv
// Self-checking bench for param_memory_module: default 16x8 instance
// plus a 64x16 instance with a non-zero clear value.
module tb_param_memory_module;

  logic       clk = 1'b0;
  logic       resetN;
  logic       clearReq;
  logic       we;
  logic [3:0] wa;
  logic [7:0] wd;
  logic       re1;
  logic [3:0] ra1;
  logic       re2;
  logic [3:0] ra2;
  logic [7:0] rd1;
  logic [7:0] rd2;
  logic       rv1;
  logic       rv2;
  logic       busy;
  logic       wdrop;

  logic        p_resetN;
  logic        p_clr;
  logic        p_we;
  logic [5:0]  p_wa;
  logic [15:0] p_wd;
  logic        p_re1;
  logic [5:0]  p_ra1;
  logic        p_re2;
  logic [5:0]  p_ra2;
  logic [15:0] p_rd1;
  logic [15:0] p_rd2;
  logic        p_rv1;
  logic        p_rv2;
  logic        p_busy;
  logic        p_wdrop;

  int checks = 0;
  int failures = 0;
  logic [7:0] model [16];

  always #5 clk = ~clk;

  param_memory_module dut (
    .clk(clk), .resetN(resetN), .clearReq(clearReq),
    .writeEnable(we), .writeAddress(wa), .writeData(wd),
    .readEnable1(re1), .readAddress1(ra1),
    .readEnable2(re2), .readAddress2(ra2),
    .readData1(rd1), .readData2(rd2),
    .readValid1(rv1), .readValid2(rv2),
    .busy(busy), .writeDropped(wdrop)
  );

  param_memory_module #(
    .DATA_WIDTH(16), .ADDR_WIDTH(6), .CLEAR_VALUE(16'hDEAD)
  ) pdut (
    .clk(clk), .resetN(p_resetN), .clearReq(p_clr),
    .writeEnable(p_we), .writeAddress(p_wa), .writeData(p_wd),
    .readEnable1(p_re1), .readAddress1(p_ra1),
    .readEnable2(p_re2), .readAddress2(p_ra2),
    .readData1(p_rd1), .readData2(p_rd2),
    .readValid1(p_rv1), .readValid2(p_rv2),
    .busy(p_busy), .writeDropped(p_wdrop)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clearReq = 0; we = 0; wa = 0; wd = 0;
    re1 = 0; ra1 = 0; re2 = 0; ra2 = 0;
  endtask

  task automatic test_reset();
    int n;
    idle();
    resetN = 0;
    cyc();
    cyc();
    checks++;
    if (busy !== 1'b1 || rv1 !== 1'b0 || rv2 !== 1'b0 ||
        rd1 !== 8'h00 || rd2 !== 8'h00 || wdrop !== 1'b0) begin
      failures++;
      $display("FAIL reset_state busy=%b rv=%b%b rd=%h/%h drop=%b want 1 00 00/00 0",
               busy, rv1, rv2, rd1, rd2, wdrop);
    end
    resetN = 1;
    n = 1;
    for (int k = 0; k < 100 && busy; k++) begin
      cyc();
      if (busy) n++;
    end
    checks++;
    if (n != 16 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_len got=%0d busy=%b want 16 then 0", n, busy);
    end
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      re1 = 1; ra1 = 4'(i); re2 = 1; ra2 = 4'(15 - i);
      cyc();
      checks++;
      if (rd1 !== 8'h00 || rd2 !== 8'h00 || rv1 !== 1'b1 || rv2 !== 1'b1) begin
        failures++;
        $display("FAIL reset_read a=%0d got=%h/%h v=%b%b want 00/00 v=11",
                 i, rd1, rd2, rv1, rv2);
      end
    end
    idle();
    cyc();
  endtask

  task automatic test_write_read();
    we = 1; wa = 4'd3; wd = 8'hA5;
    cyc();
    model[3] = 8'hA5;
    idle();
    re1 = 1; ra1 = 4'd3; re2 = 1; ra2 = 4'd3;
    cyc();
    checks++;
    if (rd1 !== 8'hA5 || rd2 !== 8'hA5 || rv1 !== 1'b1 || rv2 !== 1'b1) begin
      failures++;
      $display("FAIL write_read got=%h/%h v=%b%b want a5/a5 v=11", rd1, rd2, rv1, rv2);
    end
    idle();
    cyc();
    checks++;
    if (rv1 !== 1'b0 || rd1 !== 8'hA5 || rv2 !== 1'b0 || rd2 !== 8'hA5) begin
      failures++;
      $display("FAIL read_hold got=%h/%h v=%b%b want a5/a5 v=00", rd1, rd2, rv1, rv2);
    end
  endtask

  task automatic test_bypass();
    we = 1; wa = 4'd7; wd = 8'h11;
    cyc();
    wa = 4'd8; wd = 8'h22;
    cyc();
    model[7] = 8'h11; model[8] = 8'h22;
    wa = 4'd7; wd = 8'h3C;
    re1 = 1; ra1 = 4'd7; re2 = 1; ra2 = 4'd8;
    cyc();
    model[7] = 8'h3C;
    checks++;
    if (rd1 !== 8'h3C || rd2 !== 8'h22 || rv1 !== 1'b1 || rv2 !== 1'b1) begin
      failures++;
      $display("FAIL bypass_p1 got=%h/%h v=%b%b want 3c/22 v=11", rd1, rd2, rv1, rv2);
    end
    wa = 4'd9; wd = 8'h5A; ra1 = 4'd9; ra2 = 4'd9;
    cyc();
    model[9] = 8'h5A;
    checks++;
    if (rd1 !== 8'h5A || rd2 !== 8'h5A) begin
      failures++;
      $display("FAIL bypass_both got=%h/%h want 5a/5a", rd1, rd2);
    end
    idle();
    re1 = 1; ra1 = 4'd7; re2 = 1; ra2 = 4'd9;
    cyc();
    checks++;
    if (rd1 !== 8'h3C || rd2 !== 8'h5A) begin
      failures++;
      $display("FAIL bypass_commit got=%h/%h want 3c/5a", rd1, rd2);
    end
    idle();
    cyc();
  endtask

  task automatic test_clear();
    int n;
    for (int i = 0; i < 16; i++) begin
      we = 1; wa = 4'(i); wd = 8'hFF;
      cyc();
    end
    idle();
    clearReq = 1; we = 1; wa = 4'd0; wd = 8'h42; re1 = 1; ra1 = 4'd0;
    cyc();
    checks++;
    if (busy !== 1'b1 || rd1 !== 8'h42 || rv1 !== 1'b1) begin
      failures++;
      $display("FAIL clear_start busy=%b rd1=%h v=%b want 1 42 1", busy, rd1, rv1);
    end
    idle();
    we = 1; wa = 4'd5; wd = 8'h99; re1 = 1; ra1 = 4'd5;
    cyc();
    n = 1;
    if (busy) n++;
    checks++;
    if (wdrop !== 1'b1 || rv1 !== 1'b0 || rd1 !== 8'h42) begin
      failures++;
      $display("FAIL clear_drop drop=%b v=%b rd1=%h want 1 0 42", wdrop, rv1, rd1);
    end
    idle();
    cyc();
    if (busy) n++;
    checks++;
    if (wdrop !== 1'b0) begin
      failures++;
      $display("FAIL drop_pulse drop=%b want 0", wdrop);
    end
    for (int k = 0; k < 100 && busy; k++) begin
      cyc();
      if (busy) n++;
    end
    checks++;
    if (n != 16 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_busy_len got=%0d want 16", n);
    end
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      re1 = 1; ra1 = 4'(i); re2 = 1; ra2 = 4'(i);
      cyc();
      checks++;
      if (rd1 !== 8'h00 || rd2 !== 8'h00 || rv1 !== 1'b1) begin
        failures++;
        $display("FAIL clear_read a=%0d got=%h/%h want 00", i, rd1, rd2);
      end
    end
    idle();
    cyc();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    for (int i = 0; i < 16; i++) begin
      we = 1; wa = 4'(i); wd = 8'h77;
      cyc();
    end
    idle();
    clearReq = 1;
    cyc();
    idle();
    for (int k = 0; k < 8; k++) cyc();
    resetN = 0;
    cyc();
    resetN = 1;
    n = 1;
    for (int k = 0; k < 100 && busy; k++) begin
      cyc();
      if (busy) n++;
    end
    checks++;
    if (n != 16 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midsweep_busy_len got=%0d want 16", n);
    end
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      re2 = 1; ra2 = 4'(i);
      cyc();
      checks++;
      if (rd2 !== 8'h00 || rv2 !== 1'b1) begin
        failures++;
        $display("FAIL midsweep_read a=%0d got=%h v=%b want 00 1", i, rd2, rv2);
      end
    end
    idle();
    cyc();
  endtask

  task automatic test_random();
    logic [7:0] e1;
    logic [7:0] e2;
    logic       ev1;
    logic       ev2;
    e1 = rd1; e2 = rd2;
    for (int t = 0; t < 300; t++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = 4'($urandom_range(0, 15));
      wd  = 8'($urandom);
      re1 = 1'($urandom_range(0, 1));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      re2 = 1'($urandom_range(0, 1));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      ev1 = re1;
      ev2 = re2;
      if (re1) e1 = (we && ra1 == wa) ? wd : model[ra1];
      if (re2) e2 = (we && ra2 == wa) ? wd : model[ra2];
      if (we) model[wa] = wd;
      cyc();
      checks++;
      if (rd1 !== e1 || rv1 !== ev1) begin
        failures++;
        $display("FAIL rand_p1 t=%0d got=%h v=%b want %h v=%b", t, rd1, rv1, e1, ev1);
      end
      checks++;
      if (rd2 !== e2 || rv2 !== ev2) begin
        failures++;
        $display("FAIL rand_p2 t=%0d got=%h v=%b want %h v=%b", t, rd2, rv2, e2, ev2);
      end
    end
    idle();
    cyc();
  endtask

  task automatic test_param();
    int n;
    p_clr = 0; p_we = 0; p_wa = 0; p_wd = 0;
    p_re1 = 0; p_ra1 = 0; p_re2 = 0; p_ra2 = 0;
    p_resetN = 0;
    cyc();
    cyc();
    p_resetN = 1;
    n = 1;
    for (int k = 0; k < 200 && p_busy; k++) begin
      cyc();
      if (p_busy) n++;
    end
    checks++;
    if (n != 64 || p_busy !== 1'b0) begin
      failures++;
      $display("FAIL param_busy_len got=%0d want 64", n);
    end
    for (int i = 0; i < 64; i++) begin
      p_re1 = 1; p_ra1 = 6'(i); p_re2 = 1; p_ra2 = 6'(63 - i);
      cyc();
      checks++;
      if (p_rd1 !== 16'hDEAD || p_rd2 !== 16'hDEAD || p_rv1 !== 1'b1) begin
        failures++;
        $display("FAIL param_read a=%0d got=%h/%h want dead", i, p_rd1, p_rd2);
      end
    end
    p_re1 = 0; p_re2 = 0;
    p_we = 1; p_wa = 6'd63; p_wd = 16'hBEEF;
    cyc();
    p_we = 0; p_re1 = 1; p_ra1 = 6'd63; p_re2 = 1; p_ra2 = 6'd62;
    cyc();
    checks++;
    if (p_rd1 !== 16'hBEEF || p_rd2 !== 16'hDEAD) begin
      failures++;
      $display("FAIL param_rw got=%h/%h want beef/dead", p_rd1, p_rd2);
    end
    p_re1 = 0; p_re2 = 0;
  endtask

  initial begin
    p_resetN = 0; p_clr = 0; p_we = 0; p_wa = 0; p_wd = 0;
    p_re1 = 0; p_ra1 = 0; p_re2 = 0; p_ra2 = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    test_random();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
